// File: rtl/reservation_station_generic.sv
// Out-of-order reservation station with an age-ordered issue select and operand wakeup.
// Issue-to-writeback latency is 1 cycle. Full asserts two slots early; allocating when no slot is free drops the instruction and sets overflow.
module arithmetic_logic_unit #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      op,
  output logic [XLEN-1:0] result
);
  localparam int SW = $clog2(XLEN);

  always_comb begin
    result = '0;
    case (op)
      5'd0: result = a + b;
      5'd1: result = a - b;
      5'd2: result = a & b;
      5'd3: result = a | b;
      5'd4: result = a ^ b;
      5'd5: result = a << b[SW-1:0];
      5'd6: result = a >> b[SW-1:0];
      5'd7: result = XLEN'($signed(a) >>> b[SW-1:0]);
      5'd8: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd9: result = {{(XLEN-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end
endmodule

module reservation_station_generic #(
  parameter int DEPTH  = 16,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int NUM_WB = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_en,
  input  logic [4:0]                op_type,
  input  logic [TAG_W-1:0]          vdest_id,
  input  logic                      op1_dependent,
  input  logic [XLEN-1:0]           op1,
  input  logic                      op2_dependent,
  input  logic [XLEN-1:0]           op2,
  input  logic [NUM_WB-1:0]         ext_wb_en,
  input  logic [NUM_WB*TAG_W-1:0]   ext_wb_tag,
  input  logic [NUM_WB*XLEN-1:0]    ext_wb_val,
  output logic                      wb_out_en,
  output logic [TAG_W-1:0]          wb_out_tag,
  output logic [XLEN-1:0]           wb_out_val,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0] r_live, r_d1, r_d2;
  logic [4:0]       r_op  [DEPTH];
  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [XLEN-1:0]  r_v1  [DEPTH];
  logic [XLEN-1:0]  r_v2  [DEPTH];
  // r_older[j][i] set means entry j was allocated before entry i
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_ovf, r_wb_en;
  logic [TAG_W-1:0] r_wb_tag;
  logic [XLEN-1:0]  r_wb_val;

  logic [DEPTH-1:0] w_rdy, w_sel, w_free, w_live_nxt;
  logic             w_issue, w_bypass, w_alloc, w_drop;
  logic [IW-1:0]    w_fidx;
  logic [XLEN-1:0]  w_a, w_b, w_res;
  logic [4:0]       w_op;
  logic [TAG_W-1:0] w_tag;
  logic [XLEN:0]    w_wk1 [DEPTH];
  logic [XLEN:0]    w_wk2 [DEPTH];
  logic [XLEN:0]    w_in1, w_in2;

  // Returns {still_dependent, value}; the internal result outranks ext channel 0, which outranks 1, ...
  function automatic logic [XLEN:0] f_wake(input logic dep, input logic [XLEN-1:0] val);
    logic             d;
    logic [XLEN-1:0]  v;
    d = dep;
    v = val;
    if (dep) begin
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (ext_wb_en[k] && ext_wb_tag[k*TAG_W +: TAG_W] == val[TAG_W-1:0]) begin
          d = 1'b0;
          v = ext_wb_val[k*XLEN +: XLEN];
        end
      end
      if (r_wb_en && r_wb_tag == val[TAG_W-1:0]) begin
        d = 1'b0;
        v = r_wb_val;
      end
    end
    return {d, v};
  endfunction

  always_comb begin
    w_rdy = r_live & ~r_d1 & ~r_d2;
    w_sel = w_rdy;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && w_rdy[j] && r_older[j][i]) w_sel[i] = 1'b0;
      end
    end
    w_issue  = |w_rdy;
    w_bypass = in_en && !flush && !op1_dependent && !op2_dependent && !w_issue;
    w_free   = ~r_live | w_sel;
    w_fidx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_free[i]) w_fidx = IW'(i);
    end
    w_alloc  = in_en && !flush && !w_bypass && (|w_free);
    w_drop   = in_en && !flush && !w_bypass && !(|w_free);
    w_live_nxt = r_live & ~w_sel;
    if (w_alloc) w_live_nxt[w_fidx] = 1'b1;

    w_a   = op1;
    w_b   = op2;
    w_op  = op_type;
    w_tag = vdest_id;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_sel[i]) begin
        w_a   = r_v1[i];
        w_b   = r_v2[i];
        w_op  = r_op[i];
        w_tag = r_tag[i];
      end
      w_wk1[i] = f_wake(r_d1[i], r_v1[i]);
      w_wk2[i] = f_wake(r_d2[i], r_v2[i]);
    end
    w_in1 = f_wake(op1_dependent, op1);
    w_in2 = f_wake(op2_dependent, op2);
  end

  arithmetic_logic_unit #(.XLEN(XLEN)) u_alu (
    .a      (w_a),
    .b      (w_b),
    .op     (w_op),
    .result (w_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live   <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_wb_en  <= 1'b0;
      r_wb_tag <= '0;
      r_wb_val <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]    <= '0;
        r_tag[i]   <= '0;
        r_v1[i]    <= '0;
        r_v2[i]    <= '0;
        r_older[i] <= '0;
      end
    end else begin
      r_wb_en <= !flush && (w_issue || w_bypass);
      if (!flush && (w_issue || w_bypass)) begin
        r_wb_tag <= w_tag;
        r_wb_val <= w_res;
      end
      if (w_drop) r_ovf <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_d1[i] <= w_wk1[i][XLEN];
        r_v1[i] <= w_wk1[i][XLEN-1:0];
        r_d2[i] <= w_wk2[i][XLEN];
        r_v2[i] <= w_wk2[i][XLEN-1:0];
      end
      if (flush) begin
        r_live  <= '0;
        r_count <= '0;
      end else begin
        r_live  <= w_live_nxt;
        r_count <= r_count + CW'(w_alloc) - CW'(w_issue);
        if (w_alloc) begin
          r_op[w_fidx]  <= op_type;
          r_tag[w_fidx] <= vdest_id;
          r_d1[w_fidx]  <= w_in1[XLEN];
          r_v1[w_fidx]  <= w_in1[XLEN-1:0];
          r_d2[w_fidx]  <= w_in2[XLEN];
          r_v2[w_fidx]  <= w_in2[XLEN-1:0];
          // New entry becomes younger than every other slot
          for (int j = 0; j < DEPTH; j++) begin
            r_older[w_fidx][j] <= 1'b0;
            r_older[j][w_fidx] <= (j != int'(w_fidx));
          end
        end
      end
    end
  end

  assign wb_out_en  = r_wb_en;
  assign wb_out_tag = r_wb_tag;
  assign wb_out_val = r_wb_val;
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign full       = (r_count >= CW'(DEPTH - 2));
endmodule

// File: tb/tb_reservation_station_generic.sv
// Directed bench for reservation_station_generic: bypass vector table plus ordering, chaining, wakeup, capacity, flush and reset sequences.
module tb_reservation_station_generic;
  localparam int DEPTH = 16, XLEN = 32, TAG_W = 5, NUM_WB = 3;

  logic                    clk, rst, flush, in_en;
  logic [4:0]              op_type;
  logic [TAG_W-1:0]        vdest_id;
  logic                    op1_dependent, op2_dependent;
  logic [XLEN-1:0]         op1, op2;
  logic [NUM_WB-1:0]       ext_wb_en;
  logic [NUM_WB*TAG_W-1:0] ext_wb_tag;
  logic [NUM_WB*XLEN-1:0]  ext_wb_val;
  logic                    wb_out_en, full, overflow;
  logic [TAG_W-1:0]        wb_out_tag;
  logic [XLEN-1:0]         wb_out_val;
  logic [$clog2(DEPTH):0]  count;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic        en;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic        xen;
    logic [31:0] xval;
  } vec_t;
  vec_t vt [10];

  reservation_station_generic #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .NUM_WB(NUM_WB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_en(in_en), .op_type(op_type), .vdest_id(vdest_id),
    .op1_dependent(op1_dependent), .op1(op1), .op2_dependent(op2_dependent), .op2(op2),
    .ext_wb_en(ext_wb_en), .ext_wb_tag(ext_wb_tag), .ext_wb_val(ext_wb_val),
    .wb_out_en(wb_out_en), .wb_out_tag(wb_out_tag), .wb_out_val(wb_out_val),
    .full(full), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush = 1'b0; in_en = 1'b0; op_type = '0; vdest_id = '0;
    op1_dependent = 1'b0; op1 = '0; op2_dependent = 1'b0; op2 = '0;
    ext_wb_en = '0; ext_wb_tag = '0; ext_wb_val = '0;
  endtask

  task automatic drive(input logic [4:0] op, input logic d1, input logic [31:0] a,
                       input logic d2, input logic [31:0] b, input logic [4:0] tag);
    in_en = 1'b1; op_type = op; op1_dependent = d1; op1 = a;
    op2_dependent = d2; op2 = b; vdest_id = tag;
  endtask

  task automatic ext(input int ch, input logic [4:0] tag, input logic [31:0] val);
    ext_wb_en[ch] = 1'b1;
    ext_wb_tag[ch*TAG_W +: TAG_W] = tag;
    ext_wb_val[ch*XLEN +: XLEN] = val;
  endtask

  task automatic alloc(input logic d1, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    drive(5'd0, d1, a, 1'b0, b, tag);
    tick();
    idle_in();
  endtask

  task automatic chk_wb(input string name, input logic [4:0] tag, input logic [31:0] val);
    chk({name, "_en"}, 64'(wb_out_en), 64'(1'b1));
    chk({name, "_tag"}, 64'(wb_out_tag), 64'(tag));
    chk({name, "_val"}, 64'(wb_out_val), 64'(val));
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd0, 32'd3,          32'd4,   5'd7,  1'b1, 32'd7};
    vt[1] = '{1'b1, 5'd1, 32'd10,         32'd3,   5'd1,  1'b1, 32'd7};
    vt[2] = '{1'b1, 5'd2, 32'hF0,         32'h3C,  5'd2,  1'b1, 32'h30};
    vt[3] = '{1'b1, 5'd3, 32'hF0,         32'h0F,  5'd3,  1'b1, 32'hFF};
    vt[4] = '{1'b1, 5'd4, 32'hFF,         32'h0F,  5'd4,  1'b1, 32'hF0};
    vt[5] = '{1'b1, 5'd5, 32'd1,          32'd4,   5'd5,  1'b1, 32'h10};
    vt[6] = '{1'b1, 5'd6, 32'h80,         32'd3,   5'd6,  1'b1, 32'h10};
    vt[7] = '{1'b1, 5'd1, 32'd0,          32'd1,   5'd31, 1'b1, 32'hFFFF_FFFF};
    vt[8] = '{1'b1, 5'd0, 32'hFFFF_FFFF,  32'd1,   5'd0,  1'b1, 32'd0};
    vt[9] = '{1'b0, 5'd0, 32'd5,          32'd6,   5'd9,  1'b0, 32'd0};

    rst = 1'b1;
    idle_in();
    #2 rst = 1'b0;
    #10;
    chk("rst_wb_en", 64'(wb_out_en), 64'(1'b0));
    chk("rst_wb_tag", 64'(wb_out_tag), 64'(5'd0));
    chk("rst_wb_val", 64'(wb_out_val), 64'(32'd0));
    chk("rst_count", 64'(count), 64'(5'd0));
    chk("rst_full", 64'(full), 64'(1'b0));
    chk("rst_ovf", 64'(overflow), 64'(1'b0));
    @(negedge clk) rst = 1'b1;

    // bypass table: empty station, ready operands go straight to the ALU
    for (int i = 0; i < 10; i++) begin
      in_en = vt[i].en; op_type = vt[i].op; op1 = vt[i].a; op2 = vt[i].b;
      vdest_id = vt[i].tag; op1_dependent = 1'b0; op2_dependent = 1'b0;
      tick();
      idle_in();
      chk($sformatf("vec%0d_en", i), 64'(wb_out_en), 64'(vt[i].xen));
      if (vt[i].xen) begin
        chk($sformatf("vec%0d_tag", i), 64'(wb_out_tag), 64'(vt[i].tag));
        chk($sformatf("vec%0d_val", i), 64'(wb_out_val), 64'(vt[i].xval));
      end
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(5'd0));
    end

    // ordering: A in slot 5, B in slot 1, both woken together; A is older
    for (int i = 0; i < 5; i++) alloc(1'b1, 32'(10 + i), 32'd0, 5'(10 + i));
    chk("ord_count5", 64'(count), 64'(5'd5));
    alloc(1'b1, 32'd2, 32'd1, 5'd20);
    ext(1, 5'd11, 32'd100);
    tick();
    idle_in();
    tick();
    chk_wb("ord_free1", 5'd11, 32'd100);
    alloc(1'b1, 32'd2, 32'd2, 5'd21);
    chk("ord_gap_en", 64'(wb_out_en), 64'(1'b0));
    ext(1, 5'd2, 32'd9);
    tick();
    idle_in();
    tick();
    chk_wb("ord_A", 5'd20, 32'd10);
    tick();
    chk_wb("ord_B", 5'd21, 32'd11);
    chk("ord_count4", 64'(count), 64'(5'd4));
    flush = 1'b1;
    tick();
    idle_in();
    chk("ord_flush_count", 64'(count), 64'(5'd0));

    // chaining: Y waits on X's result broadcast
    alloc(1'b1, 32'd3, 32'd5, 5'd8);
    alloc(1'b1, 32'd8, 32'd1, 5'd9);
    ext(0, 5'd3, 32'd10);
    tick();
    idle_in();
    tick();
    chk_wb("chain_X", 5'd8, 32'd15);
    tick();
    chk("chain_gap_en", 64'(wb_out_en), 64'(1'b0));
    tick();
    chk_wb("chain_Y", 5'd9, 32'd16);
    chk("chain_count", 64'(count), 64'(5'd0));

    // internal result outranks ext channel 0 on the same tag
    alloc(1'b1, 32'd6, 32'h100, 5'd13);
    drive(5'd0, 1'b0, 32'd3, 1'b0, 32'd4, 5'd6);
    tick();
    idle_in();
    chk_wb("prio_byp", 5'd6, 32'd7);
    chk("prio_count", 64'(count), 64'(5'd1));
    ext(0, 5'd6, 32'h99);
    tick();
    idle_in();
    chk("prio_gap_en", 64'(wb_out_en), 64'(1'b0));
    tick();
    chk_wb("prio_Z", 5'd13, 32'h107);

    // same-cycle wakeup during allocation
    drive(5'd0, 1'b1, 32'd4, 1'b0, 32'd1, 5'd12);
    ext(0, 5'd4, 32'h55);
    tick();
    idle_in();
    chk("scw_en", 64'(wb_out_en), 64'(1'b0));
    chk("scw_count", 64'(count), 64'(5'd1));
    tick();
    chk_wb("scw_issue", 5'd12, 32'h56);
    chk("scw_count0", 64'(count), 64'(5'd0));

    // capacity: upper operand bits must not affect the tag match
    for (int i = 0; i < DEPTH; i++) begin
      alloc(1'b1, 32'hABCD_001E, 32'(i), 5'(i));
      chk($sformatf("cap_count%0d", i + 1), 64'(count), 64'(i + 1));
      if (i == 12) chk("cap_full13", 64'(full), 64'(1'b0));
      if (i == 13) chk("cap_full14", 64'(full), 64'(1'b1));
    end
    chk("cap_ovf0", 64'(overflow), 64'(1'b0));
    alloc(1'b1, 32'h1E, 32'd0, 5'd31);
    chk("cap_ovf1", 64'(overflow), 64'(1'b1));
    chk("cap_count16", 64'(count), 64'(5'd16));
    ext(2, 5'd30, 32'h77);
    tick();
    idle_in();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk_wb($sformatf("drain%0d", i), 5'(i), 32'h77 + 32'(i));
    end
    tick();
    chk("drain_idle", 64'(wb_out_en), 64'(1'b0));
    chk("drain_count", 64'(count), 64'(5'd0));
    chk("drain_ovf", 64'(overflow), 64'(1'b1));

    // asynchronous reset mid-cycle with a live entry and a registered result
    alloc(1'b1, 32'd25, 32'd0, 5'd25);
    drive(5'd0, 1'b0, 32'd3, 1'b0, 32'd4, 5'd7);
    tick();
    idle_in();
    chk_wb("mid_byp", 5'd7, 32'd7);
    chk("mid_count1", 64'(count), 64'(5'd1));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_en", 64'(wb_out_en), 64'(1'b0));
    chk("mid_rst_tag", 64'(wb_out_tag), 64'(5'd0));
    chk("mid_rst_val", 64'(wb_out_val), 64'(32'd0));
    chk("mid_rst_count", 64'(count), 64'(5'd0));
    chk("mid_rst_ovf", 64'(overflow), 64'(1'b0));
    chk("mid_rst_full", 64'(full), 64'(1'b0));
    @(negedge clk) rst = 1'b1;

    // flush with 5 live entries, one of them ready and an ignored allocation
    for (int i = 0; i < 5; i++) alloc(1'b1, 32'(20 + i), 32'd0, 5'(i));
    chk("fl_count5", 64'(count), 64'(5'd5));
    ext(0, 5'd20, 32'd1);
    tick();
    idle_in();
    flush = 1'b1;
    drive(5'd0, 1'b0, 32'd1, 1'b0, 32'd1, 5'd3);
    tick();
    idle_in();
    chk("fl_en", 64'(wb_out_en), 64'(1'b0));
    chk("fl_count", 64'(count), 64'(5'd0));
    tick();
    chk("fl_en2", 64'(wb_out_en), 64'(1'b0));
    chk("fl_count2", 64'(count), 64'(5'd0));
    chk("fl_full", 64'(full), 64'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/reservation_station_generic.md
RESERVATION_STATION_GENERIC -- requirements
Module: reservation_station_generic

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (power of two, 4..64).
REQ-002 SHALL have parameter XLEN, default 32, operand/result width.
REQ-003 SHALL have parameter TAG_W, default 5, vreg tag width (TAG_W <= XLEN).
REQ-004 SHALL have parameter NUM_WB, default 3, number of external writeback channels.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous assertion, active-low.
REQ-007 SHALL have port flush  input  1  synchronous squash of all entries and of the in-flight result.
REQ-008 SHALL have ports in_en/op_type[4:0]/vdest_id[TAG_W]  input, used to allocate an instruction.
REQ-009 SHALL have ports op1_dependent, op1[XLEN], op2_dependent, op2[XLEN]  input; a dependent operand carries its producer tag in [TAG_W-1:0].
REQ-010 SHALL have ports ext_wb_en[NUM_WB], ext_wb_tag[NUM_WB*TAG_W], ext_wb_val[NUM_WB*XLEN]  input, channel k in slice k.
REQ-011 SHALL have ports wb_out_en 1, wb_out_tag TAG_W, wb_out_val XLEN  output, registered ALU result broadcast.
REQ-012 SHALL have ports full 1, count [log2(DEPTH):0], overflow 1  output.

Function
REQ-013 SHALL instantiate arithmetic_logic_unit (a, b, op, result) and drive it from the selected entry or the bypassed input.
REQ-014 SHALL mark an entry ready when live and both operands non-dependent.
REQ-015 SHALL issue at most one instruction per cycle, choosing the oldest ready entry by allocation order (age matrix or equivalent), not by index.
REQ-016 SHALL bypass an incoming instruction with both operands ready directly to the ALU only when no stored entry is ready; it then occupies no slot.
REQ-017 SHALL register the issued result: wb_out_en=1, wb_out_tag=entry tag, wb_out_val=ALU result on the edge after selection (latency 1); wb_out_en=0 in idle cycles.
REQ-018 SHALL clear the issued entry's live bit on the same edge its result is registered.
REQ-019 SHALL wake a dependent operand when a writeback tag matches its stored tag; priority: wb_out (internal) first, then ext channel 0..NUM_WB-1; value and ready bit update on that edge.
REQ-020 SHALL apply the same wakeup to operands of an instruction being allocated in the same cycle (no lost wakeup).
REQ-021 SHALL allocate a non-bypassed instruction into the lowest-index free slot and make it youngest.
REQ-022 SHALL update count by +in_accepted -issued_from_slot per cycle; simultaneous allocate and issue leaves count unchanged.
REQ-023 SHALL drive full combinationally as count >= DEPTH-2 (two-slot margin for registered producers).
REQ-024 SHALL drop in_en when count == DEPTH and no slot frees that cycle, and set sticky overflow=1 until reset.
REQ-025 SHALL, on flush=1, clear all live bits, count=0, force wb_out_en=0 next cycle, and ignore in_en that cycle; flush wins over allocate and issue.
REQ-026 SHALL treat tag match width as TAG_W bits only; upper operand bits are ignored for matching.

Reset
REQ-027 SHALL on rst=0 immediately clear all live bits, age state, count=0, wb_out_en=0, wb_out_tag=0, wb_out_val=0, overflow=0, full=0.
REQ-028 SHALL resume normal operation on the first rising edge after rst returns to 1; reset mid-issue discards the in-flight result.

Verification
REQ-029 SHALL check bypass: empty RS, in_en op=ADD op1=3 op2=4 vdest=7 -> next cycle wb_out_en=1 tag=7 val=7, count stays 0.
REQ-030 SHALL check ordering: allocate A (dep tag 2) then B (dep tag 2) into slots 5 and 1; ext channel 1 tag=2 val=9 -> A issues before B despite higher index.
REQ-031 SHALL check chaining: X ready in RS, Y depends on X's tag -> X result at cycle N+1, Y captures at edge ending N+1, Y result at N+3.
REQ-032 SHALL check same-cycle wakeup: allocate op1_dependent tag 4 while ext channel 0 broadcasts tag 4 val 0x55 -> entry stored ready with 0x55, issues next cycle.
REQ-033 SHALL check capacity: fill to DEPTH with blocked entries -> full=1 at count 14 (DEPTH 16), extra in_en sets overflow=1, count stays 16.
REQ-034 SHALL check flush and reset: flush with 5 live entries -> count=0 and wb_out_en=0 next cycle; rst=0 mid-cycle -> outputs zero before the next edge.
